sprite_line_scheduler: RTL and testbench

Per-scanline object scheduler for the VGA color pipeline. During horizontal blanking it scans the player and the eight cars, builds a priority-ordered list of the objects visible on the next scanline, and then drives the shared sprite-RAM address and select on each active pixel. One frog RAM and one car RAM serve all nine objects, so the color generator only applies the returned data.

---
 rtl/game_pkg.sv | 45 ++++
 rtl/sprite_addr_calc.sv | 51 +++++
 rtl/sprite_line_scheduler.sv | 138 +++++++++++++
 tb/tb_sprite_line_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants, slot record and FSM encoding for the per-scanline sprite scheduler.
package game_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;
  localparam int MAX_SLOTS = 4;
  localparam int PLAYER_W  = 32;
  localparam int PLAYER_H  = 32;
  localparam int CAR_W     = 36;
  localparam int CAR_H     = 32;
  localparam int NUM_OBJ   = 9;

  localparam logic [3:0] ID_PLAYER    = 4'd0;
  localparam logic [3:0] ID_CAR_FIRST = 4'd1;
  localparam logic [3:0] ID_CAR_LAST  = 4'd8;

  typedef struct packed {
    logic [3:0] id;
    logic [4:0] row;
    logic [9:0] x;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Fixed lane heights of the eight cars; id 0 (the player) has no lane.
  function automatic logic [9:0] car_y(input logic [3:0] id);
    case (id)
      4'd1:    car_y = 10'd200;
      4'd2:    car_y = 10'd270;
      4'd3:    car_y = 10'd280;
      4'd4:    car_y = 10'd290;
      4'd5:    car_y = 10'd300;
      4'd6:    car_y = 10'd360;
      4'd7:    car_y = 10'd420;
      4'd8:    car_y = 10'd480;
      default: car_y = 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/sprite_addr_calc.sv
// Registers the selected object's id/row/col into the shared sprite-RAM address,
// applying the x32 frog stride, x36 car stride and the odd-car mirror.
module sprite_addr_calc
  import game_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        hit,
  input  logic [3:0]  id,
  input  logic [4:0]  row,
  input  logic [5:0]  col,
  output logic        obj_valid,
  output logic        obj_is_car,
  output logic [3:0]  obj_id,
  output logic [10:0] sprite_addr
);

  logic        is_car;
  logic [10:0] row_base;
  logic [5:0]  col_eff;
  logic [10:0] addr_next;

  always_comb begin
    is_car = (id != ID_PLAYER);
    // row*36 = row*32 + row*4
    if (is_car) row_base = {1'b0, row, 5'b0} + {4'b0, row, 2'b0};
    else        row_base = {1'b0, row, 5'b0};
    col_eff   = (is_car && id[0]) ? (6'd35 - col) : col;
    addr_next = row_base + {5'b0, col_eff};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      obj_valid   <= 1'b0;
      obj_is_car  <= 1'b0;
      obj_id      <= '0;
      sprite_addr <= '0;
    end else if (hit) begin
      obj_valid   <= 1'b1;
      obj_is_car  <= is_car;
      obj_id      <= id;
      sprite_addr <= addr_next;
    end else begin
      obj_valid   <= 1'b0;
      obj_is_car  <= 1'b0;
      obj_id      <= '0;
      sprite_addr <= '0;
    end
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Builds the next line's object list during blanking (one object per cycle),
// then picks the highest-priority covering object on each active pixel.
module sprite_line_scheduler
  import game_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [79:0] car_x,
  output logic        obj_valid,
  output logic        obj_is_car,
  output logic [3:0]  obj_id,
  output logic [10:0] sprite_addr,
  output logic [7:0]  overflow_cnt,
  output state_t      dbg_state
);

  localparam logic [9:0] H_DISP_L = 10'(H_DISPLAY);
  localparam logic [9:0] H_LAST_L = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_L = 10'(V_TOTAL - 1);

  state_t     state;
  logic [3:0] idx;
  logic [9:0] nl;
  slot_t      pend [MAX_SLOTS];
  logic [2:0] pend_cnt;
  slot_t      act  [MAX_SLOTS];
  logic [2:0] act_cnt;

  logic [9:0]  obj_x;
  logic [9:0]  obj_y;
  logic [10:0] obj_h;
  logic        scan_hit;
  logic [4:0]  scan_row;

  assign dbg_state = state;

  always_comb begin
    obj_y = (idx == ID_PLAYER) ? player_y : car_y(idx);
    obj_h = (idx == ID_PLAYER) ? 11'(PLAYER_H) : 11'(CAR_H);
    obj_x = player_x;
    for (int k = 1; k < NUM_OBJ; k++) begin
      if (idx == 4'(k)) obj_x = car_x[10*(k-1) +: 10];
    end
    scan_hit = ({1'b0, nl} >= {1'b0, obj_y}) && ({1'b0, nl} < ({1'b0, obj_y} + obj_h));
    scan_row = nl[4:0] - obj_y[4:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      idx          <= '0;
      nl           <= '0;
      pend_cnt     <= '0;
      act_cnt      <= '0;
      overflow_cnt <= '0;
      for (int s = 0; s < MAX_SLOTS; s++) begin
        pend[s] <= '0;
        act[s]  <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (h_count == H_DISP_L) begin
            state    <= ST_SCAN;
            idx      <= '0;
            pend_cnt <= '0;
            nl       <= (v_count == V_LAST_L) ? 10'd0 : v_count + 10'd1;
          end
        end
        ST_SCAN: begin
          if (scan_hit) begin
            if (pend_cnt < 3'(MAX_SLOTS)) begin
              pend[pend_cnt[1:0]] <= '{id: idx, row: scan_row, x: obj_x};
              pend_cnt            <= pend_cnt + 3'd1;
            end else if (overflow_cnt != 8'hFF) begin
              overflow_cnt <= overflow_cnt + 8'd1;
            end
          end
          if (idx == 4'(NUM_OBJ - 1)) state <= ST_WAIT;
          else                        idx   <= idx + 4'd1;
        end
        ST_WAIT: begin
          // Swap at the very end of the line so the active list never changes mid-line.
          if (h_count == H_LAST_L) begin
            act     <= pend;
            act_cnt <= pend_cnt;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic        draw_hit;
  logic [3:0]  draw_id;
  logic [4:0]  draw_row;
  logic [5:0]  draw_col;
  logic [10:0] slot_w;

  // Walk slots from last to first so the lowest-index covering slot wins.
  always_comb begin
    draw_hit = 1'b0;
    draw_id  = '0;
    draw_row = '0;
    draw_col = '0;
    slot_w   = '0;
    for (int s = MAX_SLOTS - 1; s >= 0; s--) begin
      slot_w = (act[s].id == ID_PLAYER) ? 11'(PLAYER_W) : 11'(CAR_W);
      if ((3'(s) < act_cnt) && (h_count < H_DISP_L) &&
          ({1'b0, h_count} >= {1'b0, act[s].x}) &&
          ({1'b0, h_count} < ({1'b0, act[s].x} + slot_w))) begin
        draw_hit = 1'b1;
        draw_id  = act[s].id;
        draw_row = act[s].row;
        draw_col = h_count[5:0] - act[s].x[5:0];
      end
    end
  end

  sprite_addr_calc u_addr (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .hit         (draw_hit),
    .id          (draw_id),
    .row         (draw_row),
    .col         (draw_col),
    .obj_valid   (obj_valid),
    .obj_is_car  (obj_is_car),
    .obj_id      (obj_id),
    .sprite_addr (sprite_addr)
  );

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: directed scenario tables, a reset-mid-scan sequence,
// randomized lines against a list-based reference model, and overflow saturation.
module tb_sprite_line_scheduler;
  import game_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [9:0]  h_count, v_count, player_x, player_y;
  logic [79:0] car_x;
  logic        obj_valid, obj_is_car;
  logic [3:0]  obj_id;
  logic [10:0] sprite_addr;
  logic [7:0]  overflow_cnt;
  state_t      dbg_state;

  always #5 CLK = ~CLK;

  sprite_line_scheduler dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .h_count      (h_count),
    .v_count      (v_count),
    .player_x     (player_x),
    .player_y     (player_y),
    .car_x        (car_x),
    .obj_valid    (obj_valid),
    .obj_is_car   (obj_is_car),
    .obj_id       (obj_id),
    .sprite_addr  (sprite_addr),
    .overflow_cnt (overflow_cnt),
    .dbg_state    (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct { int id; int row; int x; } tb_obj_t;
  tb_obj_t m_pend[$];
  tb_obj_t m_act[$];
  bit      m_pend_ok;
  int      m_ovf;
  int      cap_code [0:639];

  function automatic int tb_car_y(int k);
    case (k)
      1: return 200;
      2: return 270;
      3: return 280;
      4: return 290;
      5: return 300;
      6: return 360;
      7: return 420;
      8: return 480;
      default: return 0;
    endcase
  endfunction

  function automatic int mk_code(int v, int c, int id, int addr);
    return (v << 16) | (c << 15) | (id << 11) | addr;
  endfunction

  function automatic int model_pixel(int h);
    int w, col, addr;
    if (h >= 640) return 0;
    foreach (m_act[k]) begin
      w = (m_act[k].id == 0) ? 32 : 36;
      if (h >= m_act[k].x && h < m_act[k].x + w) begin
        col = h - m_act[k].x;
        if (m_act[k].id == 0)          addr = m_act[k].row * 32 + col;
        else if (m_act[k].id % 2 == 0) addr = m_act[k].row * 36 + col;
        else                           addr = m_act[k].row * 36 + (35 - col);
        return mk_code(1, (m_act[k].id != 0) ? 1 : 0, m_act[k].id, addr);
      end
    end
    return 0;
  endfunction

  task automatic model_scan(int v);
    int nl, y, x;
    tb_obj_t o;
    nl = (v == 524) ? 0 : v + 1;
    m_pend.delete();
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        y = int'(player_y);
        x = int'(player_x);
      end else begin
        y = tb_car_y(i);
        x = int'(car_x[10*(i-1) +: 10]);
      end
      if (nl >= y && nl < y + 32) begin
        if (m_pend.size() < 4) begin
          o.id = i; o.row = nl - y; o.x = x;
          m_pend.push_back(o);
        end else if (m_ovf < 255) begin
          m_ovf++;
        end
      end
    end
    m_pend_ok = 1'b1;
  endtask

  task automatic model_reset();
    m_act.delete();
    m_pend.delete();
    m_pend_ok = 1'b0;
    m_ovf     = 0;
  endtask

  // ---------------- checking / driving ----------------
  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic set_car(int id, int x);
    car_x[10*(id-1) +: 10] = 10'(x);
  endtask

  task automatic pixel(int h, int v);
    int got, exp;
    h_count = 10'(h);
    v_count = 10'(v);
    @(posedge CLK);
    #1;
    got = int'({15'b0, obj_valid, obj_is_car, obj_id, sprite_addr});
    exp = model_pixel(h);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL pix line %0d h %0d: got %h, expected %h", v, h, got, exp);
    end
    if (h < 640) cap_code[h] = got;
    if (h == 640 && RST_N) model_scan(v);
    if (h == 799) begin
      if (m_pend_ok) m_act = m_pend;
      m_pend_ok = 1'b0;
      check("overflow_cnt", int'(overflow_cnt), m_ovf);
    end
  endtask

  task automatic drive_line(int v, int chg_h, logic [79:0] chg_val);
    for (int h = 0; h < 800; h++) begin
      if (h == chg_h) car_x = chg_val;
      pixel(h, v);
    end
  endtask

  task automatic fast_line(int v);
    for (int h = 640; h <= 650; h++) pixel(h, v);
    pixel(799, v);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct { int scen; int h; int valid; int is_car; int id; int addr; } vec_t;
  vec_t vecs[$];

  task automatic add_vec(int scen, int h, int valid, int is_car, int id, int addr);
    vec_t e;
    e.scen = scen; e.h = h; e.valid = valid; e.is_car = is_car; e.id = id; e.addr = addr;
    vecs.push_back(e);
  endtask

  task automatic apply_table(int scen);
    foreach (vecs[k]) begin
      if (vecs[k].scen == scen)
        check($sformatf("scen%0d h%0d", scen, vecs[k].h), cap_code[vecs[k].h],
              mk_code(vecs[k].valid, vecs[k].is_car, vecs[k].id, vecs[k].addr));
    end
  endtask

  initial begin
    logic [79:0] far_cars, tmp;
    int v, py;

    // scen 0: frog on line 100
    add_vec(0,  99, 0, 0, 0, 0);
    add_vec(0, 100, 1, 0, 0, 0);
    add_vec(0, 131, 1, 0, 0, 31);
    add_vec(0, 132, 0, 0, 0, 0);
    // scen 7: frog clipped at right edge, line 102 row 2
    add_vec(7, 619, 0, 0, 0, 0);
    add_vec(7, 620, 1, 0, 0, 64);
    add_vec(7, 639, 1, 0, 0, 83);
    // scen 1: mirrored car 1, line 201 row 1
    add_vec(1, 199, 0, 0, 0, 0);
    add_vec(1, 200, 1, 1, 1, 71);
    add_vec(1, 235, 1, 1, 1, 36);
    add_vec(1, 236, 0, 0, 0, 0);
    // scen 5/6: car 1 moved mid-line 202, seen from line 203
    add_vec(5, 200, 1, 1, 1, 107);
    add_vec(5, 400, 0, 0, 0, 0);
    add_vec(6, 200, 0, 0, 0, 0);
    add_vec(6, 400, 1, 1, 1, 143);
    // scen 2: player over car 1, line 200
    add_vec(2, 205, 1, 1, 1, 30);
    add_vec(2, 215, 1, 0, 0, 5);
    add_vec(2, 241, 1, 0, 0, 31);
    add_vec(2, 242, 0, 0, 0, 0);
    // scen 3: five objects on line 300, car 5 dropped
    add_vec(3, 100, 1, 0, 0, 0);
    add_vec(3, 150, 1, 1, 2, 1080);
    add_vec(3, 250, 1, 1, 3, 755);
    add_vec(3, 350, 1, 1, 4, 360);
    add_vec(3, 450, 0, 0, 0, 0);
    add_vec(3, 470, 0, 0, 0, 0);
    // scen 4: frame wrap, line 0
    add_vec(4,  49, 0, 0, 0, 0);
    add_vec(4,  50, 1, 0, 0, 0);
    add_vec(4,  81, 1, 0, 0, 31);
    add_vec(4,  82, 0, 0, 0, 0);
    // scen 8/9: after reset mid-scan, line 201 blank, line 202 drawn
    add_vec(8, 200, 0, 0, 0, 0);
    add_vec(8, 300, 0, 0, 0, 0);
    add_vec(9, 200, 1, 1, 1, 107);
    add_vec(9, 300, 1, 0, 0, 64);

    // ---- reset ----
    far_cars = {8{10'd700}};
    RST_N = 1'b0; h_count = '0; v_count = '0;
    player_x = 10'd700; player_y = 10'd400; car_x = far_cars;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("rst obj_valid", int'(obj_valid), 0);
    check("rst obj_is_car", int'(obj_is_car), 0);
    check("rst obj_id", int'(obj_id), 0);
    check("rst sprite_addr", int'(sprite_addr), 0);
    check("rst overflow_cnt", int'(overflow_cnt), 0);
    check("rst state", int'(dbg_state), int'(ST_IDLE));
    RST_N = 1'b1;

    // ---- frog line 100, then clipped frog ----
    player_x = 10'd100; player_y = 10'd100;
    drive_line(99, -1, '0);
    drive_line(100, -1, '0);
    apply_table(0);
    player_x = 10'd620;
    drive_line(101, -1, '0);
    drive_line(102, -1, '0);
    apply_table(7);

    // ---- mirrored car and mid-line move ----
    player_x = 10'd700; player_y = 10'd400;
    set_car(1, 200);
    drive_line(200, -1, '0);
    drive_line(201, -1, '0);
    apply_table(1);
    tmp = car_x; tmp[9:0] = 10'd400;
    drive_line(202, 100, tmp);
    apply_table(5);
    drive_line(203, -1, '0);
    apply_table(6);

    // ---- player over car ----
    player_x = 10'd210; player_y = 10'd200;
    set_car(1, 200);
    drive_line(199, -1, '0);
    drive_line(200, -1, '0);
    apply_table(2);

    // ---- slot overflow ----
    player_x = 10'd100; player_y = 10'd300;
    car_x = far_cars;
    set_car(2, 150); set_car(3, 250); set_car(4, 350); set_car(5, 450);
    drive_line(299, -1, '0);
    check("ovf after one line", int'(overflow_cnt), 1);
    drive_line(300, -1, '0);
    apply_table(3);
    check("ovf after two lines", int'(overflow_cnt), 2);

    // ---- frame wrap ----
    player_x = 10'd50; player_y = 10'd0;
    car_x = far_cars;
    drive_line(524, -1, '0);
    drive_line(0, -1, '0);
    apply_table(4);

    // ---- randomized lines against the model ----
    for (int n = 0; n < 30; n++) begin
      v = $urandom_range(185, 335);
      if ($urandom_range(0, 7) == 0) v = 524;
      py = v + 1 - int'($urandom_range(0, 40));
      if (py < 0) py = 0;
      player_y = 10'(py);
      player_x = 10'($urandom_range(0, 700));
      for (int c = 1; c <= 8; c++) set_car(c, $urandom_range(0, 700));
      tmp = car_x;
      tmp[10*$urandom_range(0, 7) +: 10] = 10'($urandom_range(560, 700));
      drive_line(v, $urandom_range(0, 639), tmp);
    end

    // ---- reset mid-scan ----
    player_x = 10'd300; player_y = 10'd200;
    car_x = far_cars; set_car(1, 200);
    drive_line(199, -1, '0);
    for (int h = 0; h <= 645; h++) pixel(h, 200);
    check("state mid-scan", int'(dbg_state), int'(ST_SCAN));
    RST_N = 1'b0;
    model_reset();
    pixel(646, 200);
    check("rst mid obj_valid", int'(obj_valid), 0);
    check("rst mid sprite_addr", int'(sprite_addr), 0);
    check("rst mid overflow_cnt", int'(overflow_cnt), 0);
    check("rst mid state", int'(dbg_state), int'(ST_IDLE));
    RST_N = 1'b1;
    for (int h = 647; h < 800; h++) pixel(h, 200);
    drive_line(201, -1, '0);
    apply_table(8);
    drive_line(202, -1, '0);
    apply_table(9);

    // ---- overflow saturation with abbreviated blanking-only lines ----
    player_x = 10'd100; player_y = 10'd300;
    car_x = far_cars;
    set_car(2, 150); set_car(3, 250); set_car(4, 350); set_car(5, 450);
    for (int n = 1; n <= 260; n++) begin
      fast_line(300);
      if (n == 10)  check("ovf 10 lines", int'(overflow_cnt), 10);
      if (n == 254) check("ovf 254 lines", int'(overflow_cnt), 254);
      if (n == 255) check("ovf 255 lines", int'(overflow_cnt), 255);
    end
    check("ovf saturated", int'(overflow_cnt), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
